snk_game_ctrl: RTL and testbench

Game sequencer for the snake datapath. It holds the head position and the current direction, and paces movement with a programmable step tick. It accepts direction requests from the button front-end over a valid/ready handshake and rejects 180° reversals. It detects wall collisions and food hits, and runs the IDLE/RUN/DEAD game state machine that the display and scoring logic observe.

---
 rtl/snk_game_ctrl.sv | 157 +++++++++++++++
 tb/tb_snk_game_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/snk_game_ctrl.sv
// Snake game sequencer: head/direction state, step pacing, direction handshake,
// wall/food detection and IDLE/RUN/DEAD control. Define SNK_WRAP_EN for toroidal play.
module snk_game_ctrl #(
   parameter int BITS     = 4,
   parameter int TICK_DIV = 8,
   parameter int SCORE_W  = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 start,
   input  logic                 btn_valid,
   input  logic [1:0]           btn_dir,
   output logic                 btn_ready,
   input  logic [BITS-1:0]      food_x,
   input  logic [BITS-1:0]      food_y,
   output logic [1:0]           dir,
   output logic [2*BITS-1:0]    head,
   output logic                 step,
   output logic                 food_eat,
   output logic                 game_over,
   output logic                 running,
   output logic [SCORE_W-1:0]   score
);
   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [BITS-1:0] HOME      = BITS'(2 ** (BITS - 2));
   localparam logic [BITS-1:0] EDGE_HI   = '1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;

   localparam logic [1:0] D_UP = 2'b00, D_DN = 2'b01, D_LT = 2'b10, D_RT = 2'b11;

   logic [1:0]         state_q, state_d;
   logic [BITS-1:0]    x_q, x_d, y_q, y_d;
   logic [1:0]         dir_q, dir_d;
   logic               pend_vld_q, pend_vld_d;
   logic [1:0]         pend_dir_q, pend_dir_d;
   logic [TW-1:0]      tick_q, tick_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               step_q, step_d, eat_q, eat_d;

   logic [1:0]      mv_dir;
   logic [BITS-1:0] nx, ny;
   logic            hit_wall, reversal, accept;

   // The move of an evaluation uses the pending request if one is waiting.
   assign mv_dir = pend_vld_q ? pend_dir_q : dir_q;

   always_comb begin
      nx = x_q;
      ny = y_q;
      case (mv_dir)
         D_UP:    ny = y_q - 1'b1;
         D_DN:    ny = y_q + 1'b1;
         D_LT:    nx = x_q - 1'b1;
         default: nx = x_q + 1'b1;
      endcase
   end

`ifdef SNK_WRAP_EN
   assign hit_wall = 1'b0;
`else
   assign hit_wall = (mv_dir == D_UP && y_q == '0)    || (mv_dir == D_DN && y_q == EDGE_HI) ||
                     (mv_dir == D_LT && x_q == '0)    || (mv_dir == D_RT && x_q == EDGE_HI);
`endif

   assign reversal = (btn_dir[1] == dir_q[1]) && (btn_dir[0] != dir_q[0]);
   assign accept   = btn_valid && btn_ready;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      pend_vld_d = pend_vld_q;
      pend_dir_d = pend_dir_q;
      tick_d     = tick_q;
      score_d    = score_q;
      step_d     = 1'b0;
      eat_d      = 1'b0;
      case (state_q)
         S_RUN: begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            if (tick_q == TICK_LAST) begin
               dir_d      = mv_dir;
               pend_vld_d = 1'b0;
               if (hit_wall) begin
                  state_d = S_DEAD;
               end else begin
                  x_d    = nx;
                  y_d    = ny;
                  step_d = 1'b1;
                  if (nx == food_x && ny == food_y) begin
                     eat_d = 1'b1;
                     if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
                  end
               end
            end
            // Accepted after the evaluation clear, so a request on that cycle waits a step.
            if (accept && !reversal) begin
               pend_vld_d = 1'b1;
               pend_dir_d = btn_dir;
            end
         end
         S_IDLE, S_DEAD: begin
            if (start) begin
               state_d    = S_RUN;
               x_d        = HOME;
               y_d        = HOME;
               dir_d      = D_RT;
               pend_vld_d = 1'b0;
               tick_d     = '0;
               score_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         x_q        <= HOME;
         y_q        <= HOME;
         dir_q      <= D_RT;
         pend_vld_q <= 1'b0;
         pend_dir_q <= 2'b00;
         tick_q     <= '0;
         score_q    <= '0;
         step_q     <= 1'b0;
         eat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dir_q      <= dir_d;
         pend_vld_q <= pend_vld_d;
         pend_dir_q <= pend_dir_d;
         tick_q     <= tick_d;
         score_q    <= score_d;
         step_q     <= step_d;
         eat_q      <= eat_d;
      end
   end

   assign running   = (state_q == S_RUN);
   assign game_over = (state_q == S_DEAD);
   assign btn_ready = running && !pend_vld_q;
   assign dir       = dir_q;
   assign head      = {x_q, y_q};
   assign step      = step_q;
   assign food_eat  = eat_q;
   assign score     = score_q;
endmodule

// File: tb/tb_snk_game_ctrl.sv
// Randomized bench for snk_game_ctrl against a grid-level behavioural model of the game rules.
module tb_snk_game_ctrl;
   localparam int BITS = 4;
   localparam int TD   = 8;
   localparam int SW   = 8;
   localparam int N    = 1 << BITS;

   logic            CLK = 1'b0;
   logic            RST_N, start, btn_valid, btn_ready;
   logic [1:0]      btn_dir, dir;
   logic [BITS-1:0] food_x, food_y;
   logic [2*BITS-1:0] head;
   logic            step, food_eat, game_over, running;
   logic [SW-1:0]   score;

   snk_game_ctrl #(.BITS(BITS), .TICK_DIV(TD), .SCORE_W(SW)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .btn_valid(btn_valid), .btn_dir(btn_dir),
      .btn_ready(btn_ready), .food_x(food_x), .food_y(food_y), .dir(dir), .head(head),
      .step(step), .food_eat(food_eat), .game_over(game_over), .running(running), .score(score)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_fail = 0;

   // model: 0 idle, 1 run, 2 dead; pending requests held in a queue of depth <= 1
   int ms, mx, my, mdir, mtick, mscore;
   bit mstep, meat;
   int pq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      ms = 0; mx = N / 4; my = N / 4; mdir = 3; mtick = 0; mscore = 0;
      mstep = 0; meat = 0; pq.delete();
   endtask

   // One rising edge of the game, using the inputs currently driven.
   task automatic m_edge();
      int nx, ny, od;
      bit acc;
      mstep = 0; meat = 0;
      if (!RST_N) begin m_reset(); return; end
      if (ms != 1) begin
         if (start) begin
            ms = 1; mx = N / 4; my = N / 4; mdir = 3; mtick = 0; mscore = 0; pq.delete();
         end
         return;
      end
      acc = btn_valid && (pq.size() == 0);
      od  = mdir;
      if (mtick == TD - 1) begin
         if (pq.size() != 0) mdir = pq.pop_front();
         nx = mx + ((mdir == 3) ? 1 : (mdir == 2) ? -1 : 0);
         ny = my + ((mdir == 1) ? 1 : (mdir == 0) ? -1 : 0);
`ifdef SNK_WRAP_EN
         nx = (nx + N) % N; ny = (ny + N) % N;
`endif
         if (nx < 0 || nx >= N || ny < 0 || ny >= N) begin
            ms = 2;
         end else begin
            mx = nx; my = ny; mstep = 1;
            if (nx == food_x && ny == food_y) begin
               meat = 1;
               if (mscore < (1 << SW) - 1) mscore++;
            end
         end
      end
      mtick = (mtick + 1) % TD;
      if (acc && ((int'(btn_dir) ^ od) != 1)) pq.push_back(int'(btn_dir));
   endtask

   task automatic check_all();
      logic [BITS-1:0] ex, ey;
      ex = mx[BITS-1:0]; ey = my[BITS-1:0];
      check("running",   running,   ms == 1);
      check("game_over", game_over, ms == 2);
      check("btn_ready", btn_ready, ms == 1 && pq.size() == 0);
      check("head",      head,      {ex, ey});
      check("dir",       dir,       mdir[1:0]);
      check("step",      step,      mstep);
      check("food_eat",  food_eat,  meat);
      check("score",     score,     mscore[SW-1:0]);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_run"},   running,   1'b0);
      check({tag, "_over"},  game_over, 1'b0);
      check({tag, "_rdy"},   btn_ready, 1'b0);
      check({tag, "_head"},  head,      8'h44);
      check({tag, "_dir"},   dir,       2'b11);
      check({tag, "_step"},  step,      1'b0);
      check({tag, "_eat"},   food_eat,  1'b0);
      check({tag, "_score"}, score,     8'd0);
   endtask

   task automatic cyc();
      m_edge();
      @(posedge CLK);
      @(negedge CLK);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic wait_tick(input int t);
      for (int k = 0; k < 3 * TD; k++) begin
         if (mtick == t && ms == 1 && pq.size() == 0) break;
         cyc();
      end
      check("wait_tick", (mtick == t && ms == 1 && pq.size() == 0), 1'b1);
   endtask

   task automatic mid_reset();
      #3 RST_N = 1'b0;
      #1 check_reset_vals("async_rst");
      m_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_dir = 2'b00;
      food_x = '0; food_y = '0;
      m_reset();
      #12 check_reset_vals("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      // straight run to the right wall
      pulse_start();
      run(13 * TD + 4);
`ifndef SNK_WRAP_EN
      check("wall_over", game_over, 1'b1);
      check("wall_head", head, 8'hF4);
`endif

      // reversal discarded, then a turn up
      pulse_start();
      wait_tick(2);
      btn_valid = 1'b1; btn_dir = 2'b10; cyc();
      btn_dir = 2'b00; cyc();
      btn_valid = 1'b0;
      run(2 * TD);

      // request on the evaluation cycle applies only to the following move
      wait_tick(TD - 1);
      btn_valid = 1'b1; btn_dir = 2'b11; cyc();
      btn_valid = 1'b0;
      wait_tick(TD - 1);
      btn_valid = 1'b1; btn_dir = 2'b01; cyc();
      btn_valid = 1'b0;
      run(2 * TD + 2);

      // asynchronous reset mid-game, then food two cells ahead
      mid_reset();
      food_x = 4'd6; food_y = 4'd4;
      pulse_start();
      run(3 * TD);
      check("food_score", score, 8'd1);

      // pending full: held request is throttled to one transfer per step
      btn_valid = 1'b1; btn_dir = 2'b01;
      run(3 * TD);
      btn_valid = 1'b0;

      // random play
      for (int i = 0; i < 1500; i++) begin
         start     = (ms != 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
         btn_valid = $urandom_range(0, 1);
         btn_dir   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            food_x = 4'(mx + ((mdir == 3) ? 1 : (mdir == 2) ? -1 : 0));
            food_y = 4'(my + ((mdir == 1) ? 1 : (mdir == 0) ? -1 : 0));
         end else begin
            food_x = 4'($urandom_range(0, N - 1));
            food_y = 4'($urandom_range(0, N - 1));
         end
         if (i == 750 && ms == 1) mid_reset();
         else cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
